// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared TDC widths, tap-count type and clog2 helper
package tdc_pkg;

    localparam int Q_W     = 8;
    localparam int ENC_LAT = 4;

    typedef logic [Q_W-1:0] q_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdl_popcount_pipe.sv
// rtl/tdl_popcount_pipe.sv - two-stage grouped popcount of the bubble-free thermometer code
module tdl_popcount_pipe
    import tdc_pkg::*;
#(
    parameter int TDL_LEN = 90,
    parameter int GRP     = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [TDL_LEN-1:0] bits_i,
    input  logic               valid_i,
    output q_t                 q_o,
    output logic               sat_o,
    output logic               zero_o
);

    localparam int NGRP = TDL_LEN / GRP;
    localparam int GW   = clog2(GRP + 1);

    logic [GW-1:0] grp_d [NGRP];
    logic [GW-1:0] grp_q [NGRP];
    q_t            sum;
    q_t            q_d, q_q;
    logic          sat_d, sat_q;
    logic          zero_d, zero_q;

    always_comb begin
        for (int k = 0; k < NGRP; k++) begin
            grp_d[k] = '0;
            for (int j = 0; j < GRP; j++) begin
                grp_d[k] = grp_d[k] + GW'(bits_i[k*GRP+j]);
            end
        end
    end

    // valid_i is aligned with grp_q, so the total is only latched for real samples
    always_comb begin
        sum = '0;
        for (int k = 0; k < NGRP; k++) begin
            sum = sum + Q_W'(grp_q[k]);
        end
        q_d    = valid_i ? sum : q_q;
        sat_d  = valid_i && (sum == Q_W'(TDL_LEN));
        zero_d = valid_i && (sum == '0);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 0; k < NGRP; k++) begin
                grp_q[k] <= '0;
            end
            q_q    <= '0;
            sat_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < NGRP; k++) begin
                grp_q[k] <= grp_d[k];
            end
            q_q    <= q_d;
            sat_q  <= sat_d;
            zero_q <= zero_d;
        end
    end

    assign q_o    = q_q;
    assign sat_o  = sat_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/tdl_therm_encoder.sv
// rtl/tdl_therm_encoder.sv - TDL thermometer-to-count encoder; TDC_MEAN_EN adds windowed mean
module tdl_therm_encoder
    import tdc_pkg::*;
#(
    parameter int TDL_LEN  = 90,
    parameter int GRP      = 10,
    parameter int AVG_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [TDL_LEN-1:0] co_i,
    input  logic               sample_en_i,
    output q_t                 q_o,
    output logic               q_valid_o,
    output logic               sat_o,
    output logic               zero_o,
    output q_t                 mean_o,
    output logic               mean_valid_o
);

    logic [TDL_LEN-1:0] cap0_d, cap0_q;
    logic [TDL_LEN-1:0] cap1_d, cap1_q;
    logic [TDL_LEN-1:0] bub_d, bub_q;
    logic [ENC_LAT:0]   vld_d, vld_q;
    logic [TDL_LEN+1:0] ext;

    // ext pads the chain with a 1 below tap 0 and a 0 above the last tap
    always_comb begin
        cap0_d = co_i;
        cap1_d = cap0_q;
        vld_d  = {vld_q[ENC_LAT-1:0], sample_en_i};
        ext    = {1'b0, cap1_q, 1'b1};
        bub_d  = '0;
        for (int i = 0; i < TDL_LEN; i++) begin
            bub_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cap0_q <= '0;
            cap1_q <= '0;
            bub_q  <= '0;
            vld_q  <= '0;
        end else begin
            cap0_q <= cap0_d;
            cap1_q <= cap1_d;
            bub_q  <= bub_d;
            vld_q  <= vld_d;
        end
    end

    tdl_popcount_pipe #(
        .TDL_LEN (TDL_LEN),
        .GRP     (GRP)
    ) u_popcount (
        .clk     (clk),
        .rstn    (rstn),
        .bits_i  (bub_q),
        .valid_i (vld_q[ENC_LAT-1]),
        .q_o     (q_o),
        .sat_o   (sat_o),
        .zero_o  (zero_o)
    );

    assign q_valid_o = vld_q[ENC_LAT];

`ifdef TDC_MEAN_EN
    localparam int ACC_W = Q_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_d, acc_q;
    logic [AVG_LOG2-1:0] cnt_d, cnt_q;
    q_t                  mean_d, mean_q;
    logic                mean_valid_d, mean_valid_q;

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mean_d       = mean_q;
        mean_valid_d = 1'b0;
        if (q_valid_o) begin
            cnt_d = cnt_q + AVG_LOG2'(1);
            if (&cnt_q) begin
                mean_d       = q_t'((acc_q + ACC_W'(q_o)) >> AVG_LOG2);
                mean_valid_d = 1'b1;
                acc_d        = '0;
            end else begin
                acc_d = acc_q + ACC_W'(q_o);
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mean_q       <= mean_d;
            mean_valid_q <= mean_valid_d;
        end
    end

    assign mean_o       = mean_q;
    assign mean_valid_o = mean_valid_q;
`else
    logic unused_cfg;
    assign unused_cfg   = |AVG_LOG2;
    assign mean_o       = '0;
    assign mean_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_tdl_therm_encoder.sv
// tb/tb_tdl_therm_encoder.sv - self-checking bench for tdl_therm_encoder
module tb_tdl_therm_encoder;
    import tdc_pkg::*;

    localparam int N   = 90;
    localparam int AVG = 2;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [N-1:0] co_i = '0;
    logic         sample_en_i = 1'b0;
    q_t           q_o;
    logic         q_valid_o;
    logic         sat_o;
    logic         zero_o;
    q_t           mean_o;
    logic         mean_valid_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdl_therm_encoder #(
        .TDL_LEN  (N),
        .GRP      (10),
        .AVG_LOG2 (AVG)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .co_i         (co_i),
        .sample_en_i  (sample_en_i),
        .q_o          (q_o),
        .q_valid_o    (q_valid_o),
        .sat_o        (sat_o),
        .zero_o       (zero_o),
        .mean_o       (mean_o),
        .mean_valid_o (mean_valid_o)
    );

    function automatic logic [N-1:0] therm(input int n);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

    // a tap counts if at least two of {left, self, right} are ones; left of tap 0 is 1, right of top is 0
    function automatic int ref_count(input logic [N-1:0] c);
        int n;
        int votes;
        n = 0;
        for (int i = 0; i < N; i++) begin
            votes = int'(c[i]);
            votes += (i == 0) ? 1 : int'(c[i-1]);
            votes += (i == N - 1) ? 0 : int'(c[i+1]);
            if (votes >= 2) n++;
        end
        return n;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic run_one(input logic [N-1:0] co, output q_t q, output logic s, output logic z,
                           output int lat, output int width);
        @(negedge clk);
        co_i = co;
        sample_en_i = 1'b1;
        @(negedge clk);
        sample_en_i = 1'b0;
        co_i = '0;
        lat = -1;
        width = 0;
        q = '0;
        s = 1'b0;
        z = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (q_valid_o) begin
                if (lat < 0) begin
                    lat = c;
                    q = q_o;
                    s = sat_o;
                    z = zero_o;
                end
                width++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({q_o, q_valid_o, sat_o, zero_o, mean_o, mean_valid_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got q=%0d v=%b s=%b z=%b m=%0d mv=%b, want all 0",
                     q_o, q_valid_o, sat_o, zero_o, mean_o, mean_valid_o);
        end
        rstn = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({q_o, q_valid_o, sat_o, zero_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got q=%0d v=%b s=%b z=%b, want all 0",
                     q_o, q_valid_o, sat_o, zero_o);
        end
    endtask

    task automatic test_zero();
        q_t q; logic s, z; int lat, width;
        run_one('0, q, s, z, lat, width);
        n_tests++;
        if (lat !== 4 || width !== 1) begin
            n_fail++;
            $display("FAIL zero_latency: got lat=%0d width=%0d, want lat=4 width=1", lat, width);
        end
        n_tests++;
        if (q !== 8'd0 || z !== 1'b1 || s !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_value: got q=%0d z=%b s=%b, want q=0 z=1 s=0", q, z, s);
        end
    endtask

    task automatic test_bubbles();
        logic [N-1:0] pat [3];
        q_t q; logic s, z; int lat, width;
        pat[0] = therm(80);
        pat[1] = therm(80);
        pat[1][40] = 1'b0;
        pat[2] = therm(80);
        pat[2][85] = 1'b1;
        for (int p = 0; p < 3; p++) begin
            run_one(pat[p], q, s, z, lat, width);
            n_tests++;
            if (q !== 8'd80 || lat !== 4 || s !== 1'b0 || z !== 1'b0) begin
                n_fail++;
                $display("FAIL bubble_%0d: got q=%0d lat=%0d s=%b z=%b, want q=80 lat=4 s=0 z=0",
                         p, q, lat, s, z);
            end
        end
    endtask

    task automatic test_saturate();
        q_t q; logic s, z; int lat, width;
        run_one('1, q, s, z, lat, width);
        n_tests++;
        if (q !== 8'd90 || s !== 1'b1 || z !== 1'b0 || width !== 1) begin
            n_fail++;
            $display("FAIL saturate: got q=%0d s=%b z=%b w=%0d, want q=90 s=1 z=0 w=1", q, s, z, width);
        end
        n_tests++;
        if (q_o !== 8'd90 || sat_o !== 1'b0 || zero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_between: got q=%0d s=%b z=%b, want q=90 s=0 z=0", q_o, sat_o, zero_o);
        end
    endtask

    task automatic test_back_to_back();
        int cnt [3];
        logic v_seen [12];
        q_t q_seen [12];
        int first;
        cnt[0] = 10; cnt[1] = 20; cnt[2] = 30;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            co_i = therm(cnt[k]);
            sample_en_i = 1'b1;
        end
        @(negedge clk);
        sample_en_i = 1'b0;
        co_i = '0;
        first = -1;
        for (int c = 0; c < 12; c++) begin
            v_seen[c] = q_valid_o;
            q_seen[c] = q_o;
            if (q_valid_o && first < 0) first = c;
            @(negedge clk);
        end
        n_tests++;
        if (first < 0 || first > 8) begin
            n_fail++;
            $display("FAIL b2b_start: got first valid at %0d, want a valid within budget", first);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (v_seen[first+k] !== 1'b1 || q_seen[first+k] !== q_t'(cnt[k])) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got v=%b q=%0d, want v=1 q=%0d",
                             k, v_seen[first+k], q_seen[first+k], cnt[k]);
                end
            end
            n_tests++;
            if (v_seen[first+3] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_end: got v=%b after third strobe, want 0", v_seen[first+3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int strobes;
        q_t q; logic s, z; int lat, width;
        @(negedge clk);
        co_i = therm(33);
        sample_en_i = 1'b1;
        @(negedge clk);
        sample_en_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        #2 rstn = 1'b0;
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (q_valid_o) strobes++;
        end
        n_tests++;
        if (strobes !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got %0d strobes, want 0", strobes);
        end
        run_one(therm(50), q, s, z, lat, width);
        n_tests++;
        if (q !== 8'd50 || lat !== 4) begin
            n_fail++;
            $display("FAIL reset_mid_next: got q=%0d lat=%0d, want q=50 lat=4", q, lat);
        end
    endtask

    task automatic test_random();
        int exp_q [$];
        int e;
        int errs;
        int n;
        int mean_strobes;
        logic [N-1:0] v;
        errs = 0;
        mean_strobes = 0;
        for (int c = 0; c < 306; c++) begin
            @(negedge clk);
            if (mean_valid_o) mean_strobes++;
            if (q_valid_o) begin
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL rand_extra: cycle %0d got unexpected strobe q=%0d", c, q_o);
                end else begin
                    e = exp_q.pop_front();
                    if (q_o !== q_t'(e) || sat_o !== (e == N) || zero_o !== (e == 0)) begin
                        errs++;
                        $display("FAIL rand_value: cycle %0d got q=%0d s=%b z=%b, want q=%0d s=%b z=%b",
                                 c, q_o, sat_o, zero_o, e, (e == N), (e == 0));
                    end
                end
            end else if (sat_o !== 1'b0 || zero_o !== 1'b0) begin
                errs++;
                $display("FAIL rand_qualify: cycle %0d got s=%b z=%b without strobe, want 0", c, sat_o, zero_o);
            end
            if (c < 300) begin
                n = $urandom_range(0, N);
                v = therm(n);
                for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
                    v[$urandom_range(0, N - 1)] ^= 1'b1;
                end
                co_i = v;
                sample_en_i = $urandom_range(0, 1) == 1;
                if (sample_en_i) exp_q.push_back(ref_count(v));
            end else begin
                sample_en_i = 1'b0;
            end
        end
        n_tests++;
        if (errs != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_summary: got %0d errors, %0d samples never strobed, want 0 and 0",
                     errs, exp_q.size());
        end
`ifndef TDC_MEAN_EN
        n_tests++;
        if (mean_strobes != 0) begin
            n_fail++;
            $display("FAIL mean_disabled: got %0d mean strobes, want 0", mean_strobes);
        end
`endif
    endtask

    task automatic test_mean();
        int cnt [4];
        int sum;
        int strobes;
        q_t mean_seen;
        cnt[0] = 78; cnt[1] = 79; cnt[2] = 81; cnt[3] = 82;
        pulse_reset();
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            co_i = therm(cnt[k]);
            sample_en_i = 1'b1;
            sum += cnt[k];
        end
        @(negedge clk);
        sample_en_i = 1'b0;
        strobes = 0;
        mean_seen = '0;
        for (int c = 0; c < 14; c++) begin
            if (mean_valid_o) begin
                strobes++;
                mean_seen = mean_o;
            end
            @(negedge clk);
        end
`ifdef TDC_MEAN_EN
        n_tests++;
        if (strobes != 1 || mean_seen !== q_t'(sum / (1 << AVG))) begin
            n_fail++;
            $display("FAIL mean_value: got %0d strobes mean=%0d, want 1 strobe mean=%0d",
                     strobes, mean_seen, sum / (1 << AVG));
        end
`else
        n_tests++;
        if (strobes != 0 || mean_o !== 8'd0) begin
            n_fail++;
            $display("FAIL mean_off: got %0d strobes mean=%0d, want 0 strobes mean=0", strobes, mean_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_zero();
        test_bubbles();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_mean();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
